// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types, constants and width helpers for decoder_scan
// Purpose: FSM state encoding, mode constants and parameter width helpers used
//          by the one-hot decoder and the scan controller.
// Ports:   none (package).
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Number of one-hot outputs a full decode of a code of this width needs.
  function automatic int onehot_width(input int codewid);
    return 1 << codewid;
  endfunction

  // Width of a counter that must hold 0..dwell.
  function automatic int dwell_width(input int dwell);
    return (dwell < 1) ? 1 : $clog2(dwell + 1);
  endfunction

endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// rtl/decoder_scan_onehot_dec.sv - combinational MSB-first one-hot decoder
// Purpose: code k < OUTWID sets onehot_o[OUTWID-1-k]; codes >= OUTWID decode
//          to all zeros with in_range_o low.
// Ports:   code_i     [CODEWID-1:0] code to decode
//          onehot_o   [OUTWID-1:0]  MSB-first one-hot select
//          in_range_o               code_i < OUTWID
module onehot_dec #(
  parameter int CODEWID = 2,
  parameter int OUTWID  = 1 << CODEWID
) (
  input  logic [CODEWID-1:0] code_i,
  output logic [OUTWID-1:0]  onehot_o,
  output logic               in_range_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < OUTWID; i++) begin
      if (int'(code_i) == OUTWID - 1 - i) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

  assign in_range_o = int'(code_i) < OUTWID;

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered one-hot select decoder with DIRECT and SCAN modes
// Purpose: DIRECT decodes W with one cycle of latency; SCAN walks the one-hot
//          bit across all outputs, DWELL cycles per position, pulsing wrap
//          when the walk returns to code 0.
// Ports:   clk       clock, rising edge
//          rst       asynchronous active-high reset
//          En        block enable; low forces Y/valid/wrap to zero
//          mode      0 = DIRECT, 1 = SCAN
//          W         code to decode / scan start
//          load      SCAN only: re-seed position from W
//          Y         registered one-hot select, MSB-first
//          code_out  code currently driven on Y
//          valid     Y holds exactly one set bit
//          wrap      one-cycle pulse when the scan wraps to code 0
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int CODEWID = 2,
  parameter int OUTWID  = onehot_width(CODEWID),
  parameter int DWELL   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               En,
  input  logic               mode,
  input  logic [CODEWID-1:0] W,
  input  logic               load,
  output logic [OUTWID-1:0]  Y,
  output logic [CODEWID-1:0] code_out,
  output logic               valid,
  output logic               wrap
);

  localparam int               DW         = dwell_width(DWELL);
  localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
  localparam logic [CODEWID-1:0] CODE_LAST = CODEWID'(OUTWID - 1);

  state_e             state_q, state_d;
  logic [CODEWID-1:0] code_q, code_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [OUTWID-1:0]  y_q, y_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic               drive_d;
  logic [OUTWID-1:0]  dec_onehot;
  logic               dec_in_range;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    dwell_d = '0;
    wrap_d  = 1'b0;
    drive_d = 1'b0;
    if (!En) begin
      state_d = IDLE;
    end else if (mode == MODE_DIRECT) begin
      state_d = DIRECT;
      code_d  = W;
      drive_d = 1'b1;
    end else begin
      state_d = SCAN;
      drive_d = 1'b1;
      if (state_q != SCAN || load) begin
        // Entry and re-seed both restart the position from W with dwell 0.
        code_d = W;
      end else if (dwell_q == DWELL_LAST) begin
        // >= also catches an out-of-range entry code, which wraps on its
        // first advance.
        if (code_q >= CODE_LAST) begin
          code_d = '0;
          wrap_d = 1'b1;
        end else begin
          code_d = code_q + 1'b1;
        end
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // Decoding the next code lets Y, valid and wrap register together.
  onehot_dec #(
    .CODEWID(CODEWID),
    .OUTWID (OUTWID)
  ) u_dec (
    .code_i    (code_d),
    .onehot_o  (dec_onehot),
    .in_range_o(dec_in_range)
  );

  assign y_d     = drive_d ? dec_onehot : '0;
  assign valid_d = drive_d & dec_in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      dwell_q <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dwell_q <= dwell_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Y        = y_q;
  assign code_out = code_q;
  assign valid    = valid_q;
  assign wrap     = wrap_q;

endmodule
